// File: rtl/temporizador_acao.sv
// Movement sequencer for the toy: parado/frente/re/giro FSM, per-action seconds counter,
// motor direction decode and free-running display alternation clock.
module temporizador_acao #(
  parameter int DIV_SEG  = 50000000,
  parameter int DIV_MUX  = 50000,
  parameter int T_FRENTE = 9,
  parameter int T_RE     = 2,
  parameter int T_GIRO   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       habilita,
  input  logic       obstaculo,
  output logic       b3,
  output logic       b2,
  output logic       b1,
  output logic       b0,
  output logic       clk_aux,
  output logic [1:0] motor_esq,
  output logic [1:0] motor_dir,
  output logic [1:0] estado,
  output logic       fim_acao
);

  typedef enum logic [1:0] {
    PARADO = 2'b00,
    FRENTE = 2'b01,
    RE     = 2'b11,
    GIRO   = 2'b10
  } estado_t;

  localparam int SEG_W = $clog2(DIV_SEG);
  localparam int MUX_W = (DIV_MUX > 1) ? $clog2(DIV_MUX) : 1;
  localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(DIV_SEG - 1);
  localparam logic [MUX_W-1:0] MUX_LAST = MUX_W'(DIV_MUX - 1);
  localparam logic [3:0] LIM_FRENTE = 4'(T_FRENTE - 1);
  localparam logic [3:0] LIM_RE     = 4'(T_RE - 1);
  localparam logic [3:0] LIM_GIRO   = 4'(T_GIRO - 1);

  logic             hab_meta_q, hab_s_q, obs_meta_q, obs_s_q;
  estado_t          estado_q, estado_d;
  logic [3:0]       count_q, count_d;
  logic [SEG_W-1:0] presc_q, presc_d;
  logic [MUX_W-1:0] mux_cnt_q, mux_cnt_d;
  logic             clk_aux_q, clk_aux_d;
  logic             fim_q, fim_d;
  logic [1:0]       motor_esq_q, motor_esq_d, motor_dir_q, motor_dir_d;
  logic             tick, timeout;
  logic [3:0]       lim;

  assign tick = (presc_q == SEG_LAST);

  always_comb begin
    lim = LIM_FRENTE;
    case (estado_q)
      RE:      lim = LIM_RE;
      GIRO:    lim = LIM_GIRO;
      default: lim = LIM_FRENTE;
    endcase
    timeout = tick && (count_q == lim);
  end

  // habilita low dominates everything; an obstacle in FRENTE beats a coincident timeout.
  always_comb begin
    estado_d = estado_q;
    fim_d    = 1'b0;
    if (!hab_s_q) begin
      estado_d = PARADO;
    end else begin
      case (estado_q)
        PARADO: estado_d = FRENTE;
        FRENTE: begin
          if (obs_s_q) begin
            estado_d = RE;
          end else if (timeout) begin
            estado_d = RE;
            fim_d    = 1'b1;
          end
        end
        RE: begin
          if (timeout) begin
            estado_d = GIRO;
            fim_d    = 1'b1;
          end
        end
        GIRO: begin
          if (timeout) begin
            estado_d = FRENTE;
            fim_d    = 1'b1;
          end
        end
        default: estado_d = PARADO;
      endcase
    end
  end

  always_comb begin
    presc_d = presc_q + SEG_W'(1);
    count_d = count_q;
    if ((estado_d != estado_q) || (estado_q == PARADO)) begin
      presc_d = '0;
      count_d = '0;
    end else if (tick) begin
      presc_d = '0;
      count_d = count_q + 4'd1;
    end
  end

  // Motors decode the next state so they change on the same edge as estado.
  always_comb begin
    motor_esq_d = 2'b00;
    motor_dir_d = 2'b00;
    case (estado_d)
      FRENTE: begin motor_esq_d = 2'b01; motor_dir_d = 2'b01; end
      RE:     begin motor_esq_d = 2'b10; motor_dir_d = 2'b10; end
      GIRO:   begin motor_esq_d = 2'b01; motor_dir_d = 2'b10; end
      default: begin motor_esq_d = 2'b00; motor_dir_d = 2'b00; end
    endcase
  end

  always_comb begin
    mux_cnt_d = mux_cnt_q + MUX_W'(1);
    clk_aux_d = clk_aux_q;
    if (mux_cnt_q == MUX_LAST) begin
      mux_cnt_d = '0;
      clk_aux_d = ~clk_aux_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hab_meta_q  <= 1'b0;
      hab_s_q     <= 1'b0;
      obs_meta_q  <= 1'b0;
      obs_s_q     <= 1'b0;
      estado_q    <= PARADO;
      count_q     <= '0;
      presc_q     <= '0;
      mux_cnt_q   <= '0;
      clk_aux_q   <= 1'b0;
      fim_q       <= 1'b0;
      motor_esq_q <= 2'b00;
      motor_dir_q <= 2'b00;
    end else begin
      hab_meta_q  <= habilita;
      hab_s_q     <= hab_meta_q;
      obs_meta_q  <= obstaculo;
      obs_s_q     <= obs_meta_q;
      estado_q    <= estado_d;
      count_q     <= count_d;
      presc_q     <= presc_d;
      mux_cnt_q   <= mux_cnt_d;
      clk_aux_q   <= clk_aux_d;
      fim_q       <= fim_d;
      motor_esq_q <= motor_esq_d;
      motor_dir_q <= motor_dir_d;
    end
  end

  assign {b3, b2, b1, b0} = count_q;
  assign clk_aux   = clk_aux_q;
  assign motor_esq = motor_esq_q;
  assign motor_dir = motor_dir_q;
  assign estado    = estado_q;
  assign fim_acao  = fim_q;

endmodule

// File: tb/tb_temporizador_acao.sv
// Self-checking bench for temporizador_acao: directed walk through the action cycle,
// then randomized habilita/obstaculo/reset traffic against a cycle-count model.
module tb_temporizador_acao;

  localparam int DS = 4;
  localparam int DM = 3;
  localparam int TF = 3;
  localparam int TR = 2;
  localparam int TG = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       habilita = 1'b0;
  logic       obstaculo = 1'b0;
  logic       b3, b2, b1, b0, clk_aux, fim_acao;
  logic [1:0] motor_esq, motor_dir, estado;

  temporizador_acao #(
    .DIV_SEG(DS), .DIV_MUX(DM), .T_FRENTE(TF), .T_RE(TR), .T_GIRO(TG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .habilita(habilita), .obstaculo(obstaculo),
    .b3(b3), .b2(b2), .b1(b1), .b0(b0), .clk_aux(clk_aux),
    .motor_esq(motor_esq), .motor_dir(motor_dir), .estado(estado), .fim_acao(fim_acao)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: abstract action index (0 parado,1 frente,2 re,3 giro) plus cycles elapsed in it.
  int st_code[4]   = '{0, 1, 3, 2};
  int m_esq_tab[4] = '{0, 1, 2, 1};
  int m_dir_tab[4] = '{0, 1, 2, 2};
  int dur[4]       = '{0, TF*DS, TR*DS, TG*DS};
  int nxt[4]       = '{0, 2, 3, 1};
  int m_st, m_el, m_edges;
  bit m_fim;
  bit hd[2];
  bit od[2];

  task automatic model_reset();
    m_st = 0; m_el = 0; m_edges = 0; m_fim = 0;
    hd[0] = 0; hd[1] = 0; od[0] = 0; od[1] = 0;
  endtask

  task automatic model_edge();
    bit hs, os;
    int prev;
    hs = hd[1]; os = od[1];
    hd[1] = hd[0]; hd[0] = habilita;
    od[1] = od[0]; od[0] = obstaculo;
    m_edges++;
    m_fim = 0;
    prev = m_st;
    if (!hs) begin
      m_st = 0; m_el = 0;
    end else if (m_st == 0) begin
      m_st = 1; m_el = 0;
    end else if (m_st == 1 && os) begin
      m_st = 2; m_el = 0;
    end else if (m_el == dur[m_st] - 1) begin
      m_st = nxt[m_st]; m_el = 0; m_fim = 1;
    end else begin
      m_el++;
    end
    if (prev != m_st)
      $display("t=%0t action %0d -> %0d fim=%0d", $time, prev, m_st, m_fim);
  endtask

  task automatic check_outputs();
    check_eq("estado", 8'(estado), 8'(st_code[m_st]));
    check_eq("count", 8'({b3, b2, b1, b0}), 8'(m_el / DS));
    check_eq("motor_esq", 8'(motor_esq), 8'(m_esq_tab[m_st]));
    check_eq("motor_dir", 8'(motor_dir), 8'(m_dir_tab[m_st]));
    check_eq("clk_aux", 8'(clk_aux), 8'((m_edges / DM) % 2));
    check_eq("fim_acao", 8'(fim_acao), 8'(m_fim));
  endtask

  task automatic run_cycle();
    @(posedge clk);
    model_edge();
    #1 check_outputs();
  endtask

  // Called at posedge+1: asserts reset mid-cycle, checks it took effect before any edge,
  // then releases it during clock-low.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_outputs();
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int guard;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 habilita = 1'($urandom); obstaculo = 1'($urandom);
      check_outputs();
    end
    habilita = 1'b0; obstaculo = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;

    habilita = 1'b1;
    for (int i = 0; i < 60; i++) run_cycle();

    guard = 0;
    while (!(m_st == 1 && m_el / DS == 1) && guard < 100) begin run_cycle(); guard++; end
    check_eq("wait_frente_c1", 8'(guard < 100), 8'd1);
    obstaculo = 1'b1;
    run_cycle();
    obstaculo = 1'b0;
    for (int i = 0; i < 20; i++) run_cycle();

    guard = 0;
    while (m_st != 3 && guard < 100) begin run_cycle(); guard++; end
    check_eq("wait_giro", 8'(guard < 100), 8'd1);
    habilita = 1'b0;
    for (int i = 0; i < 12; i++) run_cycle();

    habilita = 1'b1;
    guard = 0;
    while (!(m_st == 2 && m_el / DS == 1) && guard < 100) begin run_cycle(); guard++; end
    check_eq("wait_re_c1", 8'(guard < 100), 8'd1);
    async_reset();
    for (int i = 0; i < 30; i++) run_cycle();

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) habilita = ~habilita;
      obstaculo = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 499) == 0) async_reset();
      run_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
